// File: rtl/input_port_unit.sv
// Input port front end for a 3D mesh router: flit FIFO, head decode, route
// handshake with the route compute unit, wormhole outport hold and switch request.
package mesh_pkg;
  typedef enum logic [2:0] {
    LOCAL = 3'd0, EAST, WEST, NORTH, SOUTH, UP, DOWN
  } port_t;

  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
    logic [1:0] z;
  } position_t;
endpackage

module input_port_unit #(
  parameter mesh_pkg::port_t THIS_INPORT = mesh_pkg::LOCAL,
  parameter int              FLIT_W      = 32,
  parameter int              DEPTH       = 4,
  parameter logic [7:0]      LFSR_SEED   = 8'hA5
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [FLIT_W-1:0]                     in_flit_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  output logic [$bits(mesh_pkg::position_t)-1:0] rcu_dest_o,
  output logic                                  rcu_rand_o,
  input  mesh_pkg::port_t                       rcu_outport_i,
  output logic                                  sa_req_o,
  output mesh_pkg::port_t                       sa_port_o,
  input  logic                                  sa_grant_i,
  output logic [FLIT_W-1:0]                     flit_o,
  output logic                                  flit_valid_o,
  output logic                                  err_o
);
  import mesh_pkg::*;

  localparam int             POS_W    = $bits(position_t);
  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  if (FLIT_W < 2 + POS_W || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      LFSR_SEED == 8'h00 || THIS_INPORT > DOWN) begin : g_param_check
    $error("input_port_unit: illegal parameterisation");
  end

  typedef enum logic [1:0] {IDLE, ROUTE, ACTIVE} state_e;

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [7:0]        lfsr_q, lfsr_d;
  state_e            state_q;
  logic [POS_W-1:0]  dest_q;
  port_t             out_port_q;
  logic [FLIT_W-1:0] flit_q;
  logic              flit_valid_q, err_q;

  logic              push, pop, pop_discard, pop_grant, fifo_empty;
  logic [FLIT_W-1:0] head_flit;
  logic [1:0]        head_type;

  assign fifo_empty = (count_q == '0);
  assign in_ready_o = (count_q != FULL_CNT);
  assign push       = in_valid_i && in_ready_o;
  assign head_flit  = mem_q[rd_ptr_q];
  assign head_type  = head_flit[1:0];

  // Type bit 0 marks a head (HEAD/HEADTAIL); bit 1 marks a tail (TAIL/HEADTAIL).
  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    pop_discard = 1'b0;
    pop_grant   = 1'b0;
    if (!fifo_empty) begin
      if (state_q == IDLE && !head_type[0]) pop_discard = 1'b1;
      if (state_q == ACTIVE && sa_grant_i)  pop_grant   = 1'b1;
    end
  end

  assign pop = pop_discard | pop_grant;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
  end

  // NOTE: storage carries no reset; pointers and count alone define valid entries.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_flit_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      lfsr_q   <= LFSR_SEED;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      lfsr_q   <= lfsr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dest_q       <= '0;
      out_port_q   <= LOCAL;
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      flit_valid_q <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            if (head_type[0]) begin
              dest_q  <= head_flit[2 +: POS_W];
              state_q <= ROUTE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ROUTE: begin
          out_port_q <= rcu_outport_i;
          state_q    <= ACTIVE;
        end
        ACTIVE: begin
          // Outport stays latched for the whole packet until the tail leaves.
          if (pop_grant) begin
            flit_q       <= head_flit;
            flit_valid_q <= 1'b1;
            if (head_type[1]) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rcu_dest_o   = dest_q;
  assign rcu_rand_o   = lfsr_q[0];
  assign sa_req_o     = (state_q == ACTIVE) && !fifo_empty;
  assign sa_port_o    = out_port_q;
  assign flit_o       = flit_q;
  assign flit_valid_o = flit_valid_q;
  assign err_o        = err_q;
endmodule

// File: tb/tb_input_port_unit.sv
// Directed bench for input_port_unit: table of single-flit packets plus
// hand-written multi-cycle sequences (wormhole, backpressure, orphans, reset).
module tb_input_port_unit;
  import mesh_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  rcu_dest;
  logic        rcu_rand;
  port_t       rcu_outport;
  logic        sa_req;
  port_t       sa_port;
  logic        sa_grant;
  logic [31:0] flit_out;
  logic        flit_valid;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  input_port_unit #(
    .THIS_INPORT(LOCAL), .FLIT_W(32), .DEPTH(4), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_flit_i(in_flit), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .rcu_dest_o(rcu_dest), .rcu_rand_o(rcu_rand), .rcu_outport_i(rcu_outport),
    .sa_req_o(sa_req), .sa_port_o(sa_port), .sa_grant_i(sa_grant),
    .flit_o(flit_out), .flit_valid_o(flit_valid), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] flit;
    logic [5:0]  dest;
    port_t       port;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!sa_req && n < 20) begin
      tick();
      n++;
    end
    check({name, "_req_timeout"}, 32'(sa_req), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   32'(in_ready),   32'd1);
    check({tag, "_sa_req"},     32'(sa_req),     32'd0);
    check({tag, "_sa_port"},    32'(sa_port),    32'(LOCAL));
    check({tag, "_rcu_dest"},   32'(rcu_dest),   32'd0);
    check({tag, "_flit_o"},     flit_out,        32'd0);
    check({tag, "_flit_valid"}, 32'(flit_valid), 32'd0);
    check({tag, "_err"},        32'(err),        32'd0);
    check({tag, "_rand"},       32'(rcu_rand),   32'd1);
  endtask

  logic [31:0] pkt [4];

  initial begin
    // Flit = {payload[31:8], dest{x,y,z}[7:2], type[1:0]}
    vecs[0] = '{32'hABCDEF63, 6'h18, EAST};   // (1,2,0)
    vecs[1] = '{32'h000001FF, 6'h3F, UP};     // (3,3,3)
    vecs[2] = '{32'h12345603, 6'h00, WEST};   // (0,0,0)
    vecs[3] = '{32'h5A5A5A9F, 6'h27, SOUTH};  // (2,1,3)

    rst_n = 1'b0; in_flit = '0; in_valid = 1'b0; rcu_outport = LOCAL; sa_grant = 1'b0;
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single HEADTAIL packets, grant held high: output 4 cycles after push.
    foreach (vecs[i]) begin
      in_flit = vecs[i].flit; in_valid = 1'b1;
      rcu_outport = vecs[i].port; sa_grant = 1'b1;
      tick();
      in_valid = 1'b0;
      check($sformatf("v%0d_early_valid", i), 32'(flit_valid), 32'd0);
      tick();
      check($sformatf("v%0d_dest", i), 32'(rcu_dest), 32'(vecs[i].dest));
      tick();
      check($sformatf("v%0d_req", i), 32'(sa_req), 32'd1);
      check($sformatf("v%0d_port", i), 32'(sa_port), 32'(vecs[i].port));
      tick();
      check($sformatf("v%0d_valid", i), 32'(flit_valid), 32'd1);
      check($sformatf("v%0d_flit", i), flit_out, vecs[i].flit);
      tick();
      check($sformatf("v%0d_valid_drop", i), 32'(flit_valid), 32'd0);
      check($sformatf("v%0d_req_drop", i), 32'(sa_req), 32'd0);
      check($sformatf("v%0d_ready", i), 32'(in_ready), 32'd1);
    end

    // 4-flit packet, dest (1,0,2), grant alternating.
    pkt[0] = 32'h11111149; pkt[1] = 32'h22222200; pkt[2] = 32'h33333300; pkt[3] = 32'h44444402;
    sa_grant = 1'b0; rcu_outport = NORTH;
    for (int i = 0; i < 4; i++) begin
      in_flit = pkt[i]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    wait_req("wh");
    check("wh_port", 32'(sa_port), 32'(NORTH));
    for (int i = 0; i < 4; i++) begin
      sa_grant = 1'b1;
      tick();
      check($sformatf("wh%0d_valid", i), 32'(flit_valid), 32'd1);
      check($sformatf("wh%0d_flit", i), flit_out, pkt[i]);
      sa_grant = 1'b0;
      tick();
      check($sformatf("wh%0d_gap", i), 32'(flit_valid), 32'd0);
      check($sformatf("wh%0d_req", i), 32'(sa_req), (i < 3) ? 32'd1 : 32'd0);
    end

    // Backpressure: fill the FIFO, a 5th flit must be refused.
    pkt[0] = 32'hA0000005; pkt[1] = 32'hA1000000; pkt[2] = 32'hA2000000; pkt[3] = 32'hA3000002;
    rcu_outport = EAST;
    for (int i = 0; i < 4; i++) begin
      in_flit = pkt[i]; in_valid = 1'b1;
      tick();
    end
    in_flit = 32'hA4000002;
    check("full_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    check("full_ready_held", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_req("full");
    sa_grant = 1'b1;
    tick();
    check("full_ready_back", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full%0d_flit", i), flit_out, pkt[i]);
      check($sformatf("full%0d_valid", i), 32'(flit_valid), 32'd1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full_drain%0d_err", i), 32'(err), 32'd0);
      check($sformatf("full_drain%0d_req", i), 32'(sa_req), 32'd0);
      check($sformatf("full_drain%0d_valid", i), 32'(flit_valid), 32'd0);
      tick();
    end
    sa_grant = 1'b0;

    // Orphan BODY flit in IDLE.
    in_flit = 32'hDEAD0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("orph_err_pre", 32'(err), 32'd0);
    tick();
    check("orph_err", 32'(err), 32'd1);
    check("orph_req", 32'(sa_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("orph_err_after%0d", i), 32'(err), 32'd0);
      check($sformatf("orph_req_after%0d", i), 32'(sa_req), 32'd0);
    end

    // Back-to-back HEADTAILs: (0,1,2) to NORTH, then (3,0,1) to DOWN.
    sa_grant = 1'b1; rcu_outport = NORTH;
    in_flit = 32'hAAAA001B; in_valid = 1'b1;
    tick();
    in_flit = 32'hBBBB00C7;
    tick();
    in_valid = 1'b0;
    check("b2b_destA", 32'(rcu_dest), 32'h06);
    tick();
    check("b2b_portA", 32'(sa_port), 32'(NORTH));
    check("b2b_reqA", 32'(sa_req), 32'd1);
    rcu_outport = DOWN;
    tick();
    check("b2b_flitA", flit_out, 32'hAAAA001B);
    check("b2b_validA", 32'(flit_valid), 32'd1);
    check("b2b_idle_req", 32'(sa_req), 32'd0);
    check("b2b_idle_port", 32'(sa_port), 32'(NORTH));
    tick();
    check("b2b_destB", 32'(rcu_dest), 32'h31);
    check("b2b_route_port", 32'(sa_port), 32'(NORTH));
    check("b2b_route_req", 32'(sa_req), 32'd0);
    tick();
    check("b2b_portB", 32'(sa_port), 32'(DOWN));
    check("b2b_reqB", 32'(sa_req), 32'd1);
    tick();
    check("b2b_flitB", flit_out, 32'hBBBB00C7);
    check("b2b_validB", 32'(flit_valid), 32'd1);

    // Mid-packet reset with two flits buffered.
    sa_grant = 1'b0; rcu_outport = WEST;
    in_flit = 32'hC0000049; in_valid = 1'b1;
    tick();
    in_flit = 32'hC1000000;
    tick();
    in_valid = 1'b0;
    wait_req("mid");
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sa_grant = 1'b1;
    check("lfsr0", 32'(rcu_rand), 32'd1);
    tick(); check("lfsr1", 32'(rcu_rand), 32'd0);
    tick(); check("lfsr2", 32'(rcu_rand), 32'd1);
    tick(); check("lfsr3", 32'(rcu_rand), 32'd0);
    tick(); check("lfsr4", 32'(rcu_rand), 32'd1);
    check("mid_flushed_req", 32'(sa_req), 32'd0);
    check("mid_flushed_valid", 32'(flit_valid), 32'd0);
    check("mid_flushed_err", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/input_port_unit.md
Name: input_port_unit

Overview:
- Per-inport front end of a 3D mesh router; sits directly upstream of the single-port route compute unit.
- Buffers incoming flits and extracts the destination from each head flit.
- Drives the route compute unit's dest and rand_bit inputs, latches the returned outport for the whole packet (wormhole), then requests the switch and streams flits out on grant.

Parameters:
- THIS_INPORT, port_t LOCAL: inport this unit serves; also the constant inport fed to the route compute unit.
- FLIT_W, 32: flit width in bits. Must satisfy FLIT_W >= 2 + $bits(position_t).
- DEPTH, 4: FIFO depth in flits. Power of two, >= 2.
- LFSR_SEED, 8'hA5: LFSR reset value. Must be nonzero.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_flit_i  in  FLIT_W  incoming flit
- in_valid_i  in  1  upstream flit valid
- in_ready_o  out  1  FIFO can accept a flit
- rcu_dest_o  out  $bits(position_t)  destination presented to the route compute unit
- rcu_rand_o  out  1  random bit for the route compute unit's backup choice
- rcu_outport_i  in  port_t  route compute result
- sa_req_o  out  1  switch allocation request
- sa_port_o  out  port_t  requested output port
- sa_grant_i  in  1  grant for current request
- flit_o  out  FLIT_W  flit to crossbar
- flit_valid_o  out  1  flit_o valid this cycle
- err_o  out  1  one-cycle pulse: orphan body/tail flit dropped

Behaviour:
- Flit type is flit[1:0]: 00 BODY, 01 HEAD, 10 TAIL, 11 HEADTAIL.
- Head and headtail flits carry the destination position_t in flit[2 +: $bits(position_t)].
- FIFO
  - Push when in_valid_i && in_ready_o.
  - in_ready_o = (count != DEPTH), from registered count. A pop in the same cycle does not free space for a push when full.
  - Simultaneous push and pop when neither full nor empty: count unchanged.
  - Pointers wrap modulo DEPTH.
  - A pushed flit is visible at the FIFO head the next cycle.
- LFSR
  - 8-bit Galois, taps x^8+x^6+x^5+x^4+1, shifts every cycle.
  - rcu_rand_o = lfsr[0].
  - Reset value LFSR_SEED.
- FSM states: IDLE, ROUTE, ACTIVE.
  - IDLE, FIFO empty: stay.
  - IDLE, head is HEAD or HEADTAIL: register the dest field into rcu_dest_o and go to ROUTE.
  - IDLE, head is BODY or TAIL: pop and discard it, pulse err_o next cycle, stay IDLE.
  - ROUTE, 1 cycle: rcu_dest_o is stable; capture rcu_outport_i into out_port_q at the clock edge; go to ACTIVE.
  - ACTIVE: sa_req_o = (FIFO non-empty); sa_port_o = out_port_q.
    - On sa_grant_i && sa_req_o: pop the head, and next cycle flit_o = that flit with flit_valid_o = 1.
    - If the popped flit is TAIL or HEADTAIL, go to IDLE; otherwise stay.
  - A grant while sa_req_o = 0 is ignored.
  - In ACTIVE the FIFO is empty mid-packet: sa_req_o = 0, hold state and out_port_q.
- Latency
  - Head push at edge t gives rcu_dest_o valid after edge t+1.
  - out_port_q is captured at edge t+2; sa_req_o is high from t+2.
  - A grant in cycle g gives flit_valid_o in cycle g+1.
  - Minimum head-to-output latency: 4 cycles.
- The next packet's head waits in IDLE for one cycle after its predecessor's tail pops. No back-to-back route overlap.
- Reset values (asynchronous; also applies mid-packet, discarding all buffered flits):
  - state IDLE, count 0, pointers 0, lfsr LFSR_SEED
  - in_ready_o 1, sa_req_o 0, sa_port_o LOCAL, out_port_q LOCAL
  - rcu_dest_o 0, flit_o 0, flit_valid_o 0, err_o 0

Test Plan:
- Single HEADTAIL flit, dest (1,2,0), rcu_outport_i tied EAST, grant held 1 -> sa_port_o = EAST; flit_o equals the input flit with flit_valid_o high exactly 4 cycles after push; returns to IDLE; count 0.
- 4-flit packet (HEAD, BODY, BODY, TAIL) with sa_grant_i alternating 1/0 -> four flit_valid_o pulses in order, each the cycle after a grant; sa_req_o drops after the TAIL pop.
- Push 4 flits with grant held 0 -> in_ready_o = 0 after the 4th; a 5th valid flit is not accepted; a grant then restores in_ready_o one cycle after the pop.
- BODY flit arriving in IDLE -> popped, err_o pulses exactly once, no sa_req_o.
- Two back-to-back HEADTAIL packets routed NORTH then DOWN -> sa_port_o changes only after the first packet's pop, with one IDLE cycle between them.
- rst_n asserted low for one cycle mid-packet (2 flits buffered, ACTIVE) -> all outputs at reset values immediately; rcu_rand_o sequence restarts from bit 0 of 8'hA5 (= 1).
